// File: rtl/tick_timer_scheduler_if.sv
// Purpose: configuration write bus and expiry-event valid/ready port of the timer scheduler.
// Latency: none; signal bundle only.
// Backpressure: evt_ready from the consumer holds evt_valid/evt_ch stable while low.
// Ports: cfg_we/cfg_ch/cfg_start/cfg_mode/cfg_period (controller -> scheduler),
//        evt_valid/evt_ch (scheduler -> controller), evt_ready (controller -> scheduler).
interface tick_timer_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int CH_W   = 2
);
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic             cfg_start;
    logic             cfg_mode;
    logic [CNT_W-1:0] cfg_period;
    logic             evt_valid;
    logic [CH_W-1:0]  evt_ch;
    logic             evt_ready;

    // Controller side: writes configuration, consumes events.
    modport master (
        output cfg_we, cfg_ch, cfg_start, cfg_mode, cfg_period, evt_ready,
        input  evt_valid, evt_ch
    );

    // Scheduler side.
    modport slave (
        input  cfg_we, cfg_ch, cfg_start, cfg_mode, cfg_period, evt_ready,
        output evt_valid, evt_ch
    );
endinterface

// File: rtl/tick_timer_scheduler.sv
// Purpose: NUM_CH one-shot/periodic timers on a shared prescaled base tick, events round-robin arbitrated.
// Latency: expiry in tick cycle t -> pending at edge t+1 -> evt_valid at edge t+2 (slot free).
// Backpressure: evt_valid/evt_ch held while evt_ready=0; repeat expiries merge and set sticky overflow.
// Ports: clk, rst (sync, active high); bus (slave modport: cfg write bus in, event port out);
//        base_tick (1-cycle pulse every TICK_DIV clocks); ch_active (armed bits); overflow (sticky).
module tick_timer_scheduler #(
    parameter int TICK_DIV = 50000,
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int CH_W     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    tick_timer_scheduler_if.slave     bus,
    output logic                      base_tick,
    output logic [NUM_CH-1:0]         ch_active,
    output logic [NUM_CH-1:0]         overflow
);

    localparam int               PS_W    = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Free-running prescaler; base_tick is registered off the wrap.
    // ------------------------------------------------------------------
    logic [PS_W-1:0] ps_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_cnt    <= '0;
            base_tick <= 1'b0;
        end else if (ps_cnt == PS_LAST) begin
            ps_cnt    <= '0;
            base_tick <= 1'b1;
        end else begin
            ps_cnt    <= ps_cnt + 1'b1;
            base_tick <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Channel state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  period_q    [NUM_CH];
    logic [CNT_W-1:0]  remaining_q [NUM_CH];
    logic [NUM_CH-1:0] mode_q;
    logic [NUM_CH-1:0] active_q;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] overflow_q;

    logic [NUM_CH-1:0] cfg_hit;
    logic [NUM_CH-1:0] tick_en;
    logic [NUM_CH-1:0] expire;

    // A cfg write to a channel masks that channel's tick in the same cycle.
    always_comb begin
        cfg_hit = '0;
        tick_en = '0;
        expire  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_hit[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
            tick_en[i] = base_tick && active_q[i] && !cfg_hit[i];
            expire[i]  = tick_en[i] && (remaining_q[i] == CNT_ONE);
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter: first pending channel at or after rr_ptr.
    // ------------------------------------------------------------------
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   cand;
    logic [CH_W-1:0]   sel;
    logic              found;
    logic              slot_free;
    logic              grant;
    logic [NUM_CH-1:0] grant_oh;

    always_comb begin
        cand     = '0;
        sel      = '0;
        found    = 1'b0;
        grant_oh = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            if (!found && pending_q[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        slot_free = !bus.evt_valid || bus.evt_ready;
        grant     = slot_free && found;
        if (grant) begin
            grant_oh[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i]    <= '0;
                remaining_q[i] <= '0;
            end
            mode_q     <= '0;
            active_q   <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_hit[i] && bus.cfg_start && (bus.cfg_period != '0)) begin
                    period_q[i]    <= bus.cfg_period;
                    remaining_q[i] <= bus.cfg_period;
                    mode_q[i]      <= bus.cfg_mode;
                    active_q[i]    <= 1'b1;
                    pending_q[i]   <= 1'b0;
                    overflow_q[i]  <= 1'b0;
                end else if (cfg_hit[i] && !bus.cfg_start) begin
                    active_q[i]  <= 1'b0;
                    pending_q[i] <= 1'b0;
                end else if (expire[i]) begin
                    // An expiry colliding with its own grant re-arms pending
                    // without counting as an overflow.
                    pending_q[i] <= 1'b1;
                    if (pending_q[i] && !grant_oh[i]) begin
                        overflow_q[i] <= 1'b1;
                    end
                    if (mode_q[i]) begin
                        remaining_q[i] <= period_q[i];
                    end else begin
                        active_q[i] <= 1'b0;
                    end
                end else begin
                    if (grant_oh[i]) begin
                        pending_q[i] <= 1'b0;
                    end
                    if (tick_en[i] && (remaining_q[i] > CNT_ONE)) begin
                        remaining_q[i] <= remaining_q[i] - CNT_ONE;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Event output slot
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.evt_valid <= 1'b0;
            bus.evt_ch    <= '0;
            rr_ptr        <= '0;
        end else if (grant) begin
            bus.evt_valid <= 1'b1;
            bus.evt_ch    <= sel;
            rr_ptr        <= (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + 1'b1;
        end else if (slot_free) begin
            bus.evt_valid <= 1'b0;
        end
    end

    assign ch_active = active_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_tick_timer_scheduler.sv
// Purpose: directed-vector bench for tick_timer_scheduler with TICK_DIV=4.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: evt_ready driven per scenario to exercise hold and overflow.
module tb_tick_timer_scheduler;
    localparam int TD = 4;
    localparam int N  = 4;
    localparam int CW = 16;
    localparam int HW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          base_tick;
    logic [N-1:0]  ch_active;
    logic [N-1:0]  overflow;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tick_timer_scheduler_if #(.NUM_CH(N), .CNT_W(CW), .CH_W(HW)) bus ();

    tick_timer_scheduler #(
        .TICK_DIV(TD), .NUM_CH(N), .CNT_W(CW), .CH_W(HW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .base_tick (base_tick),
        .ch_active (ch_active),
        .overflow  (overflow)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_idle;
        bus.cfg_we     = 1'b0;
        bus.cfg_ch     = '0;
        bus.cfg_start  = 1'b0;
        bus.cfg_mode   = 1'b0;
        bus.cfg_period = '0;
    endtask

    task automatic cfg_write(input int ch, input bit start, input bit mode, input int period);
        bus.cfg_we     = 1'b1;
        bus.cfg_ch     = HW'(ch);
        bus.cfg_start  = start;
        bus.cfg_mode   = mode;
        bus.cfg_period = CW'(period);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        cfg_idle();
        bus.evt_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Steps until base_tick is seen; caller is then in the tick cycle.
    task automatic wait_tick;
        int n = 0;
        while (base_tick !== 1'b1 && n < 3 * TD) begin
            step();
            n++;
        end
        vectors++;
        if (base_tick !== 1'b1) begin
            $display("FAIL wait_tick: base_tick=%b after %0d cycles, required 1", base_tick, n);
            miscompares++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cfg_idle();
        bus.evt_ready = 1'b1;
        step();
        step();
        vectors++;
        if ({base_tick, bus.evt_valid, bus.evt_ch, ch_active, overflow} !== '0) begin
            $display("FAIL reset_state: tick=%b vld=%b ch=%0d act=%b ovf=%b, required all 0",
                     base_tick, bus.evt_valid, bus.evt_ch, ch_active, overflow);
            miscompares++;
        end
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            vectors++;
            if (base_tick !== ((k % TD) == 0)) begin
                $display("FAIL reset_tick k=%0d: got %b required %b", k, base_tick, (k % TD) == 0);
                miscompares++;
            end
            vectors++;
            if ({bus.evt_valid, ch_active, overflow} !== '0) begin
                $display("FAIL reset_idle k=%0d: vld=%b act=%b ovf=%b, required 0",
                         k, bus.evt_valid, ch_active, overflow);
                miscompares++;
            end
        end
    endtask

    task automatic test_oneshot;
        logic         exp_vld;
        logic [N-1:0] exp_act;
        do_reset();
        wait_tick();
        cfg_write(1, 1'b1, 1'b0, 3);
        for (int m = 1; m <= 20; m++) begin
            step();
            if (m == 1) cfg_idle();
            exp_act = (m <= 12) ? 4'b0010 : 4'b0000;
            exp_vld = (m == 14);
            vectors++;
            if (ch_active !== exp_act) begin
                $display("FAIL oneshot_act m=%0d: got %b required %b", m, ch_active, exp_act);
                miscompares++;
            end
            vectors++;
            if (bus.evt_valid !== exp_vld) begin
                $display("FAIL oneshot_vld m=%0d: got %b required %b", m, bus.evt_valid, exp_vld);
                miscompares++;
            end
            if (exp_vld) begin
                vectors++;
                if (bus.evt_ch !== 2'd1) begin
                    $display("FAIL oneshot_ch m=%0d: got %0d required 1", m, bus.evt_ch);
                    miscompares++;
                end
            end
        end
    endtask

    task automatic test_periodic;
        logic         exp_vld;
        logic [N-1:0] exp_act;
        do_reset();
        wait_tick();
        cfg_write(0, 1'b1, 1'b1, 2);
        for (int m = 1; m <= 44; m++) begin
            step();
            if (m == 1 || m == 28) cfg_idle();
            exp_act = (m <= 27) ? 4'b0001 : 4'b0000;
            exp_vld = (m >= 10) && (m <= 26) && (((m - 10) % 8) == 0);
            vectors++;
            if (ch_active !== exp_act) begin
                $display("FAIL periodic_act m=%0d: got %b required %b", m, ch_active, exp_act);
                miscompares++;
            end
            vectors++;
            if (bus.evt_valid !== exp_vld) begin
                $display("FAIL periodic_vld m=%0d: got %b required %b", m, bus.evt_valid, exp_vld);
                miscompares++;
            end
            if (exp_vld) begin
                vectors++;
                if (bus.evt_ch !== 2'd0) begin
                    $display("FAIL periodic_ch m=%0d: got %0d required 0", m, bus.evt_ch);
                    miscompares++;
                end
            end
            if (m == 27) cfg_write(0, 1'b0, 1'b0, 0);
        end
    endtask

    // Arms all channels periodic period=1 starting in a tick cycle so that
    // every channel expires on the same following tick (cycle 4).
    task automatic arm_all_period1;
        wait_tick();
        for (int c = 0; c < N; c++) begin
            cfg_write(c, 1'b1, 1'b1, 1);
            step();
        end
        cfg_idle();
    endtask

    task automatic test_back_to_back;
        logic [HW-1:0] exp_ch;
        do_reset();
        arm_all_period1();
        for (int m = 5; m <= 25; m++) begin
            step();
            exp_ch = HW'((m - 6) % N);
            vectors++;
            if (bus.evt_valid !== (m >= 6)) begin
                $display("FAIL b2b_vld m=%0d: got %b required %b", m, bus.evt_valid, m >= 6);
                miscompares++;
            end
            if (m >= 6) begin
                vectors++;
                if (bus.evt_ch !== exp_ch) begin
                    $display("FAIL b2b_ch m=%0d: got %0d required %0d", m, bus.evt_ch, exp_ch);
                    miscompares++;
                end
            end
            vectors++;
            if (overflow !== 4'b0000) begin
                $display("FAIL b2b_ovf m=%0d: got %b required 0000", m, overflow);
                miscompares++;
            end
        end
    endtask

    task automatic test_backpressure;
        logic [HW-1:0] exp_ch;
        logic [N-1:0]  exp_ovf;
        do_reset();
        bus.evt_ready = 1'b0;
        arm_all_period1();
        for (int m = 5; m <= 21; m++) begin
            step();
            exp_ch  = (m <= 9) ? 2'd0 : HW'((m - 9) % N);
            exp_ovf = (m >= 9) ? 4'b1110 : 4'b0000;
            vectors++;
            if (bus.evt_valid !== (m >= 6)) begin
                $display("FAIL bp_vld m=%0d: got %b required %b", m, bus.evt_valid, m >= 6);
                miscompares++;
            end
            if (m >= 6) begin
                vectors++;
                if (bus.evt_ch !== exp_ch) begin
                    $display("FAIL bp_ch m=%0d: got %0d required %0d", m, bus.evt_ch, exp_ch);
                    miscompares++;
                end
            end
            vectors++;
            if (overflow !== exp_ovf) begin
                $display("FAIL bp_ovf m=%0d: got %b required %b", m, overflow, exp_ovf);
                miscompares++;
            end
            if (m == 9) bus.evt_ready = 1'b1;
        end
    endtask

    task automatic test_cfg_edge;
        logic         exp_vld;
        logic [N-1:0] exp_act;
        do_reset();
        cfg_write(2, 1'b1, 1'b1, 0);
        step();
        cfg_idle();
        for (int k = 0; k < 6; k++) begin
            step();
            vectors++;
            if ({bus.evt_valid, ch_active} !== '0) begin
                $display("FAIL zero_period k=%0d: vld=%b act=%b required 0", k, bus.evt_valid, ch_active);
                miscompares++;
            end
        end
        // Armed during a tick: that tick must not count, so the event
        // follows the second tick after arming, not the first.
        wait_tick();
        cfg_write(2, 1'b1, 1'b0, 2);
        for (int m = 1; m <= 11; m++) begin
            step();
            if (m == 1) cfg_idle();
            exp_act = (m <= 8) ? 4'b0100 : 4'b0000;
            exp_vld = (m == 10);
            vectors++;
            if (ch_active !== exp_act) begin
                $display("FAIL coinc_act m=%0d: got %b required %b", m, ch_active, exp_act);
                miscompares++;
            end
            vectors++;
            if (bus.evt_valid !== exp_vld) begin
                $display("FAIL coinc_vld m=%0d: got %b required %b", m, bus.evt_valid, exp_vld);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_mid;
        wait_tick();
        bus.evt_ready = 1'b0;
        cfg_write(2, 1'b1, 1'b1, 2);
        for (int m = 1; m <= 10; m++) begin
            step();
            if (m == 1) cfg_idle();
        end
        vectors++;
        if ({bus.evt_valid, bus.evt_ch, ch_active} !== {1'b1, 2'd2, 4'b0100}) begin
            $display("FAIL pre_rst: vld=%b ch=%0d act=%b required 1/2/0100",
                     bus.evt_valid, bus.evt_ch, ch_active);
            miscompares++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({base_tick, bus.evt_valid, bus.evt_ch, ch_active, overflow} !== '0) begin
            $display("FAIL mid_rst: tick=%b vld=%b ch=%0d act=%b ovf=%b required all 0",
                     base_tick, bus.evt_valid, bus.evt_ch, ch_active, overflow);
            miscompares++;
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            vectors++;
            if (base_tick !== (k == 4) || bus.evt_valid !== 1'b0) begin
                $display("FAIL post_rst k=%0d: tick=%b vld=%b required %b/0",
                         k, base_tick, bus.evt_valid, k == 4);
                miscompares++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_idle();
        bus.evt_ready = 1'b1;
        test_reset();
        test_oneshot();
        test_periodic();
        test_back_to_back();
        test_backpressure();
        test_cfg_edge();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
